// File: rtl/axis_result_serializer_pkg.sv
// Shared definitions for the result-side serializer.
// Holds the default geometry, which matches the systolic-array top, plus the
// FSM state encoding and the helper that sizes the lane/row counters.
package axis_result_serializer_pkg;

    localparam int unsigned DEFAULT_N            = 32'd4;
    localparam int unsigned DEFAULT_RESULT_WIDTH = 32'd32;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_DRAIN = 1'b1
    } ser_state_e;

    // Counter width for indexing N lanes or rows. The result is never below 1,
    // so a degenerate N=1 still gets a legal vector.
    function automatic int unsigned lane_idx_w(input int unsigned n);
        return (n > 32'd1) ? $clog2(n) : 32'd1;
    endfunction

    localparam int unsigned LANE_IDX_W = lane_idx_w(DEFAULT_N);

endpackage

// File: rtl/axis_result_serializer.sv
// Width down-converter for the systolic-array result stream.
// One wide beat (a full output row of N lanes) is taken in and emitted as N
// narrow words, lane 0 first. tuser marks the last word of a row, and tlast
// marks the last word of every N-row matrix.
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous, active-low reset
//   s_axis_tdata   result row, lane k = bits [k*RESULT_WIDTH +: RESULT_WIDTH]
//   s_axis_tvalid  row beat valid
//   s_axis_tready  serializer can accept a row
//   m_axis_tdata   serialized result word
//   m_axis_tvalid  word valid
//   m_axis_tready  downstream accepts word
//   m_axis_tuser   last word of the current row
//   m_axis_tlast   last word of the matrix
module axis_result_serializer
    import axis_result_serializer_pkg::*;
#(
    parameter int unsigned N            = DEFAULT_N,
    parameter int unsigned RESULT_WIDTH = DEFAULT_RESULT_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N*RESULT_WIDTH-1:0] s_axis_tdata,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    output logic [RESULT_WIDTH-1:0]   m_axis_tdata,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic                      m_axis_tuser,
    output logic                      m_axis_tlast
);

    localparam int unsigned        IW       = lane_idx_w(N);
    localparam logic [IW-1:0]      LAST_IDX = IW'(N - 32'd1);
    localparam logic [IW-1:0]      ONE_IDX  = IW'(32'd1);

    ser_state_e                state_q, state_d;
    logic [IW-1:0]             lane_q, lane_d;
    logic [IW-1:0]             row_q, row_d;
    logic [N*RESULT_WIDTH-1:0] hold_q, hold_d;
    // Keeps s_axis_tready low while reset is held and for the reset cycle
    // itself, so no beat is taken before the block is out of reset.
    logic                      ready_en_q;

    logic                      lane_last_s;
    logic                      row_last_s;
    logic [RESULT_WIDTH-1:0]   lane_word_s;

    assign lane_last_s = (lane_q == LAST_IDX);
    assign row_last_s  = (row_q == LAST_IDX);

    // Lane select mux over the holding register.
    always_comb begin
        lane_word_s = '0;
        for (int k = 0; k < int'(N); k++) begin
            if (lane_q == IW'(k)) begin
                lane_word_s = hold_q[k*RESULT_WIDTH +: RESULT_WIDTH];
            end else begin
                lane_word_s = lane_word_s;
            end
        end
    end

    // Next-state logic and stream handshake outputs.
    always_comb begin
        state_d       = state_q;
        lane_d        = lane_q;
        row_d         = row_q;
        hold_d        = hold_q;
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                s_axis_tready = ready_en_q;
                if (s_axis_tvalid && ready_en_q) begin
                    hold_d  = s_axis_tdata;
                    lane_d  = '0;
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_EMPTY;
                end
            end
            ST_DRAIN: begin
                m_axis_tvalid = 1'b1;
                // Accepting the next row only while the final word leaves keeps
                // rows back-to-back without ever overwriting an undrained row.
                s_axis_tready = lane_last_s && m_axis_tready;
                if (m_axis_tready) begin
                    if (lane_last_s) begin
                        row_d  = row_last_s ? '0 : (row_q + ONE_IDX);
                        lane_d = '0;
                        if (s_axis_tvalid) begin
                            hold_d  = s_axis_tdata;
                            state_d = ST_DRAIN;
                        end else begin
                            state_d = ST_EMPTY;
                        end
                    end else begin
                        lane_d = lane_q + ONE_IDX;
                    end
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_EMPTY;
                lane_d  = '0;
                row_d   = '0;
            end
        endcase
    end

    // Word-side outputs are driven only while draining, so idle reads as zero.
    always_comb begin
        if (state_q == ST_DRAIN) begin
            m_axis_tdata = lane_word_s;
            m_axis_tuser = lane_last_s;
            m_axis_tlast = lane_last_s && row_last_s;
        end else begin
            m_axis_tdata = '0;
            m_axis_tuser = 1'b0;
            m_axis_tlast = 1'b0;
        end
    end

    // State, counter and holding registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_EMPTY;
            lane_q     <= '0;
            row_q      <= '0;
            hold_q     <= '0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lane_q     <= lane_d;
            row_q      <= row_d;
            hold_q     <= hold_d;
            ready_en_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_axis_result_serializer.sv
// Directed self-checking bench for axis_result_serializer (N=4, 32-bit words).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_axis_result_serializer;

    logic         clk;
    logic         reset;
    logic [127:0] s_axis_tdata;
    logic         s_axis_tvalid;
    logic         s_axis_tready;
    logic [31:0]  m_axis_tdata;
    logic         m_axis_tvalid;
    logic         m_axis_tready;
    logic         m_axis_tuser;
    logic         m_axis_tlast;

    int n_cmp;
    int n_err;

    // {s_ready, m_valid, m_user, m_last, m_data}
    logic [35:0] obs_s;
    assign obs_s = {s_axis_tready, m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata};

    axis_result_serializer dut (
        .clk           (clk),
        .reset         (reset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tlast  (m_axis_tlast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] row_data(input int id);
        logic [127:0] r;
        case (id)
            100:     r = {32'h0000_0033, 32'h0000_0022, 32'h0000_0011, 32'h0000_0000};
            101:     r = {32'h0000_0001, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
            default: begin
                for (int k = 0; k < 4; k++) begin
                    r[k*32 +: 32] = 32'hC0DE_0000 | (id << 4) | k;
                end
            end
        endcase
        return r;
    endfunction

    function automatic logic [31:0] word(input int id, input int lane);
        logic [127:0] r;
        r = row_data(id);
        return r[lane*32 +: 32];
    endfunction

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [35:0] exp);
        n_cmp++;
        assert (obs_s === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs_s, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk(tag, {1'b1, 1'b1 ^ 1'b1, 1'b0, 1'b0, 32'h0000_0000});
    endtask

    // Called at the falling edge that shows lane 0 of row `id`; checks its four
    // words and presents the next beat while the row drains.
    task automatic drain_row(input int id, input int rim, input logic nxt_v, input int nxt_id);
        for (int l = 0; l < 4; l++) begin
            chk($sformatf("row%0d_lane%0d", id, l),
                {(l == 3) && m_axis_tready, 1'b1, (l == 3), (l == 3) && (rim == 3), word(id, l)});
            if (l == 0) begin
                s_axis_tvalid = nxt_v;
                s_axis_tdata  = row_data(nxt_id);
            end else begin
                s_axis_tvalid = s_axis_tvalid;
            end
            cyc();
        end
    endtask

    task automatic do_reset();
        reset         = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        m_axis_tready = 1'b1;
        cyc();
        cyc();
        chk("reset_outputs", 36'h0_0000_0000);
        reset = 1'b1;
        cyc();
        chk_idle("after_release");
    endtask

    initial begin
        int ptr;
        int c;
        int lane;
        n_cmp = 0;
        n_err = 0;
        reset = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        m_axis_tready = 1'b1;

        // Single row
        do_reset();
        s_axis_tdata  = row_data(100);
        s_axis_tvalid = 1'b1;
        cyc();
        drain_row(100, 0, 1'b0, 0);
        chk_idle("single_row_done");

        // Full matrix back-to-back plus a fifth row restarting at row 0
        do_reset();
        s_axis_tdata  = row_data(0);
        s_axis_tvalid = 1'b1;
        cyc();
        drain_row(0, 0, 1'b1, 1);
        drain_row(1, 1, 1'b1, 2);
        drain_row(2, 2, 1'b1, 3);
        drain_row(3, 3, 1'b1, 4);
        drain_row(4, 0, 1'b0, 0);
        chk_idle("matrix_done");

        // Backpressure: m_axis_tready pattern 1,0,0 repeating over two rows
        do_reset();
        s_axis_tdata  = row_data(20);
        s_axis_tvalid = 1'b1;
        cyc();
        s_axis_tdata = row_data(21);
        ptr = 0;
        c   = 0;
        while (ptr < 8 && c < 60) begin
            if (ptr >= 4) s_axis_tvalid = 1'b0;
            else          s_axis_tvalid = s_axis_tvalid;
            m_axis_tready = ((c % 3) == 0);
            #1;
            lane = ptr % 4;
            chk($sformatf("bp_word%0d_cyc%0d", ptr, c),
                {(lane == 3) && m_axis_tready, 1'b1, (lane == 3), 1'b0,
                 word((ptr < 4) ? 20 : 21, lane)});
            if (m_axis_tready) ptr++;
            else               ptr = ptr;
            c++;
            cyc();
        end
        n_cmp++;
        assert (ptr == 8) else begin
            n_err++;
            $error("FAIL bp_timeout: observed %0d words expected 8", ptr);
        end
        m_axis_tready = 1'b1;
        #1;
        chk_idle("bp_done");
        cyc();

        // Input stall of three cycles between rows 1 and 2
        do_reset();
        s_axis_tdata  = row_data(30);
        s_axis_tvalid = 1'b1;
        cyc();
        drain_row(30, 0, 1'b1, 31);
        drain_row(31, 1, 1'b0, 0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("stall_idle%0d", i), {1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000});
            if (i == 2) begin
                s_axis_tdata  = row_data(32);
                s_axis_tvalid = 1'b1;
            end else begin
                s_axis_tvalid = 1'b0;
            end
            cyc();
        end
        drain_row(32, 2, 1'b1, 33);
        drain_row(33, 3, 1'b0, 0);
        chk_idle("stall_done");

        // Reset in the middle of a matrix
        do_reset();
        s_axis_tdata  = row_data(40);
        s_axis_tvalid = 1'b1;
        cyc();
        drain_row(40, 0, 1'b1, 41);
        s_axis_tvalid = 1'b0;
        chk("mid_w4", {1'b0, 1'b1, 1'b0, 1'b0, word(41, 0)});
        cyc();
        chk("mid_w5", {1'b0, 1'b1, 1'b0, 1'b0, word(41, 1)});
        cyc();
        chk("mid_w6", {1'b0, 1'b1, 1'b0, 1'b0, word(41, 2)});
        reset = 1'b0;
        cyc();
        chk("mid_reset_outputs", 36'h0_0000_0000);
        reset = 1'b1;
        cyc();
        chk_idle("mid_after_release");
        s_axis_tdata  = row_data(42);
        s_axis_tvalid = 1'b1;
        cyc();
        drain_row(42, 0, 1'b1, 43);
        drain_row(43, 1, 1'b1, 44);
        drain_row(44, 2, 1'b1, 45);
        drain_row(45, 3, 1'b0, 0);
        chk_idle("mid_done");

        // Extreme data values, passed bit-exact
        s_axis_tdata  = row_data(101);
        s_axis_tvalid = 1'b1;
        cyc();
        drain_row(101, 0, 1'b0, 0);
        chk_idle("maxval_done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
